// File: rtl/down_cnt_reload_timer.sv
// Loadable down-counter timer with terminal-count pulse, sticky one-shot done flag
// and auto-reload from the last loaded value for periodic ticks.
module down_cnt_reload_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             mode,
  input  logic             clr_done,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             done,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  // running is kept as its own register, updated alongside every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      reload_reg <= '0;
      state      <= ST_IDLE;
      tc         <= 1'b0;
      done       <= 1'b0;
      running    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        cnt        <= din;
        reload_reg <= din;
        state      <= ST_IDLE;
        done       <= 1'b0;
        running    <= 1'b0;
      end else if (state == ST_DONE) begin
        if (clr_done) begin
          done    <= 1'b0;
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      end else if (en && (cnt != '0)) begin
        if (cnt == ONE) begin
          tc <= 1'b1;
          if (mode) begin
            cnt     <= reload_reg;
            state   <= ST_RUN;
            running <= 1'b1;
          end else begin
            cnt     <= '0;
            done    <= 1'b1;
            state   <= ST_DONE;
            running <= 1'b0;
          end
        end else begin
          cnt     <= cnt - ONE;
          state   <= ST_RUN;
          running <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_cnt_reload_timer.sv
// Scoreboard bench for down_cnt_reload_timer: stimulus pushes expected post-edge
// outputs, a monitor pops and compares them after each rising edge.
module tb_down_cnt_reload_timer;

  typedef struct {
    string      name;
    logic [3:0] cnt;
    logic       tc;
    logic       done;
    logic       running;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic       en;
  logic       mode;
  logic       clr_done;
  logic [3:0] cnt;
  logic       tc;
  logic       done;
  logic       running;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb[$];

  down_cnt_reload_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .en       (en),
    .mode     (mode),
    .clr_done (clr_done),
    .cnt      (cnt),
    .tc       (tc),
    .done     (done),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic compare(input string nm, input logic [3:0] ec, input logic et,
                         input logic ed, input logic er);
    total++;
    if (cnt !== ec || tc !== et || done !== ed || running !== er) begin
      bad++;
      $display("FAIL %s: got cnt=%0d tc=%b done=%b running=%b, want cnt=%0d tc=%b done=%b running=%b",
               nm, cnt, tc, done, running, ec, et, ed, er);
    end
  endtask

  // Monitor: one expected entry per rising edge that had stimulus queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e.name, e.cnt, e.tc, e.done, e.running);
      end
    end
  end

  task automatic step(input string nm, input logic ld, input logic [3:0] d,
                      input logic e, input logic m, input logic c,
                      input logic [3:0] ec, input logic et, input logic ed, input logic er);
    exp_t x;
    @(negedge clk);
    load = ld; din = d; en = e; mode = m; clr_done = c;
    x.name = nm; x.cnt = ec; x.tc = et; x.done = ed; x.running = er;
    sb.push_back(x);
  endtask

  int          seq_ar[12] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
  int unsigned waited;

  initial begin
    rst = 1'b1; load = 1'b0; din = '0; en = 1'b0; mode = 1'b0; clr_done = 1'b0;
    #12;
    compare("reset_initial", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot from 4
    step("os_load", 1, 4'd4, 0, 0, 0, 4'd4, 0, 0, 0);
    step("os_3",    0, 4'd0, 1, 0, 0, 4'd3, 0, 0, 1);
    step("os_2",    0, 4'd0, 1, 0, 0, 4'd2, 0, 0, 1);
    step("os_1",    0, 4'd0, 1, 0, 0, 4'd1, 0, 0, 1);
    step("os_exp",  0, 4'd0, 1, 0, 0, 4'd0, 1, 1, 0);
    step("os_hold1",0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0);
    step("os_hold2",0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0);
    step("os_clr",  0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
    step("idle_z",  0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 0);

    // Auto-reload from 3, 12 enabled cycles -> 4 tc pulses
    step("ar_load", 1, 4'd3, 0, 1, 0, 4'd3, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      step($sformatf("ar_%0d", i), 0, 4'd0, 1, 1, 0, 4'(seq_ar[i]),
           (seq_ar[i] == 3) ? 1'b1 : 1'b0, 0, 1);

    // Pause at 7 then resume; clr_done in RUN has no effect
    step("pa_load", 1, 4'd10, 0, 0, 0, 4'd10, 0, 0, 0);
    step("pa_9",    0, 4'd0, 1, 0, 0, 4'd9, 0, 0, 1);
    step("pa_8",    0, 4'd0, 1, 0, 0, 4'd8, 0, 0, 1);
    step("pa_7",    0, 4'd0, 1, 0, 0, 4'd7, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step($sformatf("pa_hold%0d", i), 0, 4'd0, 0, 0, 1, 4'd7, 0, 0, 1);
    step("pa_6",    0, 4'd0, 1, 0, 0, 4'd6, 0, 0, 1);
    step("pa_5",    0, 4'd0, 1, 0, 0, 4'd5, 0, 0, 1);

    // Asynchronous reset mid-count at cnt=7 in RUN
    step("rs_load", 1, 4'd9, 0, 0, 0, 4'd9, 0, 0, 0);
    step("rs_8",    0, 4'd0, 1, 0, 0, 4'd8, 0, 0, 1);
    step("rs_7",    0, 4'd0, 1, 0, 0, 4'd7, 0, 0, 1);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1 compare("reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Load wins over en and clr_done while in DONE
    step("si_load1", 1, 4'd1, 0, 0, 0, 4'd1, 0, 0, 0);
    step("si_exp",   0, 4'd0, 1, 0, 0, 4'd0, 1, 1, 0);
    step("si_load15",1, 4'd15, 1, 0, 1, 4'd15, 0, 0, 0);
    step("si_hold",  0, 4'd0, 0, 0, 0, 4'd15, 0, 0, 0);

    // Load zero never fires
    step("z_load",  1, 4'd0, 1, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("z_%0d", i), 0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 0);

    // Mode only matters at the expiry edge
    step("mc_load", 1, 4'd2, 0, 0, 0, 4'd2, 0, 0, 0);
    step("mc_1",    0, 4'd0, 1, 0, 0, 4'd1, 0, 0, 1);
    step("mc_exp",  0, 4'd0, 1, 1, 0, 4'd2, 1, 0, 1);

    // Maximum value: 15 enabled cycles to expiry, no wrap
    step("mx_load", 1, 4'd15, 0, 0, 0, 4'd15, 0, 0, 0);
    for (int i = 14; i >= 1; i--)
      step($sformatf("mx_%0d", i), 0, 4'd0, 1, 0, 0, 4'(i), 0, 0, 1);
    step("mx_exp",  0, 4'd0, 1, 0, 0, 4'd0, 1, 1, 0);
    step("mx_nw1",  0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0);
    step("mx_nw2",  0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0);

    @(negedge clk);
    load = 1'b0; en = 1'b0; clr_done = 1'b0;
    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
